bbs_sequencer: RTL
==================

Name: bbs_sequencer

Overview:
Control FSM that runs the Blum-Blum-Shub bit generator. It drives an external modular squarer (x -> x^2 mod M) and waits that unit's fixed latency. It then feeds the squarer result back as the next seed and shifts each result LSB into an NBITS-wide output word. It sits between the gen-button flag and the show/display path, and gives start/busy/done sequencing plus seed loading.

Parameters:
NBITS, 256, number of random bits produced per run (>=2)
SEED_W, 16, width of seed and squarer operands
SEED_INIT, 884, seed value after reset
SQ_LAT, 1, squarer latency in clk cycles from sq_x stable to sq_y valid (>=1)
CNT_W, 9, width of bit_cnt; must satisfy 2^CNT_W > NBITS

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
gen_req  in  1  single-cycle start pulse (button flag)
seed_load  in  1  single-cycle pulse: load seed_in into the seed register
seed_in  in  SEED_W  new seed value
sq_x  out  SEED_W  operand to the squarer; always equals the seed register
sq_y  in  SEED_W  squarer result, sampled SQ_LAT cycles after ISSUE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run completes
bit_cnt  out  CNT_W  bits captured in the current or last run
result  out  NBITS  shift register of generated bits, newest bit at [0]

Behaviour:
- Reset values:
  - state=IDLE, seed=SEED_INIT, result=0, bit_cnt=0, busy=0, done=0, wait counter=0.
  - Reset has priority in any state and aborts a run mid-operation with no done pulse.
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - gen_req=1 -> ISSUE; bit_cnt cleared to 0. result is not cleared; a full run overwrites all NBITS bits.
  - seed_load=1 -> seed<=seed_in.
  - Both in the same cycle: seed is loaded and the run starts, using the new seed in ISSUE.
- ISSUE (1 cycle): wait counter <= SQ_LAT-1 -> WAIT.
- WAIT (SQ_LAT cycles): wait counter decrements each cycle; at 0 -> CAPTURE.
- CAPTURE (1 cycle):
  - seed<=sq_y; result<={result[NBITS-2:0], sq_y[0]}; bit_cnt<=bit_cnt+1.
  - If bit_cnt+1==NBITS -> DONE, else -> ISSUE.
- DONE (1 cycle): done=1 -> IDLE. busy is still 1 in DONE and drops in the next cycle.
- sq_x is stable from ISSUE through CAPTURE because seed changes only in CAPTURE, on seed_load in IDLE, or on reset.
- Timing:
  - Each bit takes SQ_LAT+2 cycles.
  - A run takes NBITS*(SQ_LAT+2)+1 cycles from the first ISSUE to DONE inclusive.
  - Defaults: 768 cycles to the last CAPTURE, done in cycle 769.
- gen_req while busy: ignored (unless the optional feature is enabled).
- seed_load while busy: ignored; seed is never corrupted mid-run.
- Arithmetic: bit_cnt compares are full CNT_W wide. No modular arithmetic is done here.
- Degenerate seeds 0 or 1 are not filtered: a seed of 0 yields all-zero bits and a seed of 1 yields all-one bits.

Optional Feature:
Macro BBS_SEQ_QUEUE_EN.
- Defined: adds a 1-deep pending flag.
  - gen_req while busy sets pending; further requests while pending=1 are dropped.
  - In DONE with pending=1: pending clears, next state is ISSUE (not IDLE), bit_cnt is cleared, and done still pulses.
  - Reset clears pending.
  - Adds output port pending (1 bit, reset 0).
- Undefined: no pending port; gen_req while busy is lost.

Test Plan:
1. Reset, then gen_req at cycle 0 (NBITS=4, SQ_LAT=1, bench squarer mod 40633 registered 1 cycle) -> sq_x=884; captured seeds 9429, 1037, 18911, 14888; result=4'b1110; done=1 in cycle 13 only; busy 1 in cycles 1-13.
2. In IDLE, seed_load=1 with seed_in=1037 and gen_req in the same cycle (NBITS=4) -> first sq_x=1037; captured seeds 18911, 14888, ...; bit_cnt=4 at done.
3. seed_load with seed_in=5 during WAIT of the 2nd bit -> ignored; captured sequence identical to scenario 1; seed_load in IDLE afterwards -> sq_x=5.
4. gen_req pulsed in cycle 5 of a run, macro undefined -> exactly one done pulse, returns to IDLE. Macro defined -> pending=1; second run starts in the cycle after DONE; two done pulses 13 cycles apart.
5. reset asserted in cycle 7 mid-run -> next cycle state IDLE, busy=0, sq_x=884, result=0, bit_cnt=0, no done pulse.
6. Default parameters, SQ_LAT=3 -> done at cycle 256*5+1=1281 after the start cycle; bit_cnt=256; result[255:253]=3'b111 (first three bits from 884).

Source files
------------

// File: rtl/bbs_sequencer.sv
// Blum-Blum-Shub sequencer: drives an external x^2 mod M squarer and collects result LSBs into an NBITS word.
// Optional macro BBS_SEQ_QUEUE_EN adds a 1-deep pending start request and the pending output.
module bbs_sequencer #(
    parameter int          NBITS     = 256,
    parameter int          SEED_W    = 16,
    parameter int unsigned SEED_INIT = 884,
    parameter int          SQ_LAT    = 1,
    parameter int          CNT_W     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gen_req,
    input  logic              seed_load,
    input  logic [SEED_W-1:0] seed_in,
    output logic [SEED_W-1:0] sq_x,
    input  logic [SEED_W-1:0] sq_y,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic [NBITS-1:0]  result
`ifdef BBS_SEQ_QUEUE_EN
    ,
    output logic              pending
`endif
);

    localparam int WC_W = (SQ_LAT > 1) ? $clog2(SQ_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SEED_W-1:0] seed_q, seed_d;
    logic [NBITS-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              done_d;
`ifdef BBS_SEQ_QUEUE_EN
    logic              pend_q, pend_d;
`endif

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        done_d   = 1'b0;
`ifdef BBS_SEQ_QUEUE_EN
        pend_d   = pend_q;
        // A request arriving mid-run is remembered once; extra ones are dropped.
        if (state_q != S_IDLE && gen_req && !pend_q) begin
            pend_d = 1'b1;
        end
`endif
        unique case (state_q)
            S_IDLE: begin
                if (seed_load) begin
                    seed_d = seed_in;
                end
                if (gen_req) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                wait_d  = WC_W'(SQ_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                seed_d   = sq_y;
                result_d = {result_q[NBITS-2:0], sq_y[0]};
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_d == CNT_W'(NBITS)) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef BBS_SEQ_QUEUE_EN
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            seed_q   <= SEED_W'(SEED_INIT);
            result_q <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
`ifdef BBS_SEQ_QUEUE_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            wait_q   <= wait_d;
`ifdef BBS_SEQ_QUEUE_EN
            pend_q   <= pend_d;
`endif
        end
    end

    assign sq_x    = seed_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_d;
    assign bit_cnt = cnt_q;
    assign result  = result_q;
`ifdef BBS_SEQ_QUEUE_EN
    assign pending = pend_q;
`endif

endmodule
